// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply (shift-add) / divide (restoring)
// with architectural HI/LO registers and a busy/done handshake.
// One iteration per clock; WIDTH iterations per operation, then a FINISH
// cycle in which done pulses and HI/LO already hold the new result.
module muldiv_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic               op_q;
   // Multiplicand for multiply, divisor for divide.
   logic [WIDTH-1:0]   opnd_q;
   // Multiply: {partial product, remaining multiplier bits}.
   // Divide:   {partial remainder, dividend bits / quotient bits}.
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_step;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               dbz_q;
   logic               last_iter;

   // One shift-add step: conditionally add the multiplicand into the upper
   // half (keeping the carry), then shift the whole accumulator right.
   function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   mcand);
      logic [WIDTH:0] sum;
      sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : '0)};
      return {sum, acc[WIDTH-1:1]};
   endfunction

   // One restoring step: shift the next dividend MSB into the remainder,
   // compare against the divisor at WIDTH+1 bits, keep or restore.
   function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   dvsr);
      logic [WIDTH:0]   shifted;
      logic [WIDTH-1:0] rem_new;
      shifted = acc[2*WIDTH-1:WIDTH-1];
      rem_new = WIDTH'(shifted - {1'b0, dvsr});
      if (shifted >= {1'b0, dvsr}) begin
         return {rem_new, acc[WIDTH-2:0], 1'b1};
      end
      return {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
   endfunction

   assign acc_step  = op_q ? div_step(acc_q, opnd_q) : mul_step(acc_q, opnd_q);
   assign last_iter = (state_q == RUN) && (cnt_q == LAST_ITER);

   // Next-state logic for the IDLE -> RUN -> FINISH sequence.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (last_iter) state_d = FINISH;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Operand capture, iteration engine, HI/LO and divide-by-zero flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         op_q   <= 1'b0;
         opnd_q <= '0;
         acc_q  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         dbz_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  // Start wins over a same-cycle move; the move is dropped.
                  cnt_q  <= '0;
                  op_q   <= op;
                  opnd_q <= op ? b : a;
                  acc_q  <= {{WIDTH{1'b0}}, (op ? a : b)};
               end else begin
                  if (hi_we) hi_q <= wdata;
                  if (lo_we) lo_q <= wdata;
               end
            end
            RUN: begin
               acc_q <= acc_step;
               cnt_q <= cnt_q + CNT_W'(1);
               // Publish on the final iteration so FINISH already shows it.
               if (last_iter) begin
                  hi_q  <= acc_step[2*WIDTH-1:WIDTH];
                  lo_q  <= acc_step[WIDTH-1:0];
                  dbz_q <= op_q && (opnd_q == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy        = (state_q == RUN);
   assign done        = (state_q == FINISH);
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: vector table plus random ops through a scoreboard,
// then moves, start/move conflicts, start-while-busy and mid-operation reset.
module tb_muldiv_unit;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         reset, start, op, hi_we, lo_we;
   logic [W-1:0] a, b, wdata;
   logic         busy, done, dbz;
   logic [W-1:0] hi, lo;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic         op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
   } vec_t;

   vec_t         exp_q[$];
   vec_t         tbl[10];
   logic [W-1:0] m_hi, m_lo;
   logic         m_dbz;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
      .div_by_zero(dbz), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Launch one operation, optionally with a same-cycle LO move (dropped) and
   // a start/HI move poked mid-run (ignored); check timing and result.
   task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed,
                         input bit with_lo_we, input bit poke);
      vec_t e;
      vec_t got;
      int   k;
      int   nbusy;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      if (with_lo_we) begin
         lo_we = 1'b1; wdata = 16'hBEEF;
      end
      e = '{op: o, a: x, b: y, hi: eh, lo: el, dbz: ed};
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0; lo_we = 1'b0; a = '0; b = '0;
      k = 1; nbusy = 0;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      chk("lo_stable_in_run", {16'd0, lo}, {16'd0, m_lo});
      while (k < 40 && done !== 1'b1) begin
         if (busy === 1'b1) nbusy++;
         if (poke && k == 3) begin
            start = 1'b1; op = 1'b0; a = 16'd9; b = 16'd9; hi_we = 1'b1; wdata = 16'h7777;
         end else begin
            start = 1'b0; hi_we = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0; hi_we = 1'b0;
      if (done !== 1'b1) begin
         chk("done_timeout", 32'd0, 32'd1);
         return;
      end
      chk("done_latency", k, 17);
      chk("busy_cycles", nbusy, 16);
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
         chk("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      got = exp_q.pop_front();
      chk("result_hi", {16'd0, hi}, {16'd0, got.hi});
      chk("result_lo", {16'd0, lo}, {16'd0, got.lo});
      chk("div_by_zero", {31'd0, dbz}, {31'd0, got.dbz});
      m_hi = got.hi; m_lo = got.lo; m_dbz = got.dbz;
      @(negedge clk);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
   endtask

   task automatic do_move(input logic hw, input logic lw, input logic [W-1:0] d);
      @(negedge clk);
      hi_we = hw; lo_we = lw; wdata = d;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      if (hw) m_hi = d;
      if (lw) m_lo = d;
      chk("move_hi", {16'd0, hi}, {16'd0, m_hi});
      chk("move_lo", {16'd0, lo}, {16'd0, m_lo});
      chk("move_no_done", {31'd0, done}, 32'd0);
      chk("move_keeps_dbz", {31'd0, dbz}, {31'd0, m_dbz});
   endtask

   initial begin
      logic [2*W-1:0] prod;
      logic [W-1:0]   ra, rb;
      logic           rop;

      tbl[0] = '{1'b0, 16'd300,   16'd200,   16'h0000, 16'hEA60, 1'b0};
      tbl[1] = '{1'b0, 16'hFFFF,  16'hFFFF,  16'hFFFE, 16'h0001, 1'b0};
      tbl[2] = '{1'b1, 16'd1000,  16'd7,     16'h0006, 16'h008E, 1'b0};
      tbl[3] = '{1'b1, 16'd5,     16'd9,     16'h0005, 16'h0000, 1'b0};
      tbl[4] = '{1'b1, 16'h1234,  16'h0000,  16'h1234, 16'hFFFF, 1'b1};
      tbl[5] = '{1'b0, 16'd2,     16'd3,     16'h0000, 16'h0006, 1'b0};
      tbl[6] = '{1'b1, 16'h8000,  16'd3,     16'h0002, 16'h2AAA, 1'b0};
      tbl[7] = '{1'b1, 16'hFFFF,  16'd1,     16'h0000, 16'hFFFF, 1'b0};
      tbl[8] = '{1'b0, 16'h1234,  16'h0000,  16'h0000, 16'h0000, 1'b0};
      tbl[9] = '{1'b0, 16'h8000,  16'h0002,  16'h0001, 16'h0000, 1'b0};

      reset = 1'b1; start = 1'b0; op = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      a = '0; b = '0; wdata = '0;
      m_hi = '0; m_lo = '0; m_dbz = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_dbz", {31'd0, dbz}, 32'd0);
      chk("reset_hi", {16'd0, hi}, 32'd0);
      chk("reset_lo", {16'd0, lo}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dbz, 1'b0, 1'b0);
      end

      for (int i = 0; i < 6; i++) begin
         ra  = W'($urandom);
         rb  = (i == 5) ? '0 : W'($urandom_range(0, 255));
         rop = (i % 2 == 1);
         if (!rop) begin
            prod = {{W{1'b0}}, ra} * {{W{1'b0}}, rb};
            run_op(rop, ra, rb, prod[2*W-1:W], prod[W-1:0], 1'b0, 1'b0, 1'b0);
         end else if (rb == '0) begin
            run_op(rop, ra, rb, ra, '1, 1'b1, 1'b0, 1'b0);
         end else begin
            run_op(rop, ra, rb, ra % rb, ra / rb, 1'b0, 1'b0, 1'b0);
         end
      end

      // Moves in IDLE: HI alone, then LO alone, then both together.
      do_move(1'b1, 1'b0, 16'hABCD);
      do_move(1'b0, 1'b1, 16'h1357);
      do_move(1'b1, 1'b1, 16'h2468);

      // Start together with lo_we: the move is dropped, lo=12.
      run_op(1'b0, 16'd3, 16'd4, 16'h0000, 16'd12, 1'b0, 1'b1, 1'b0);

      // Second start (a=9) and an HI move while busy are both ignored.
      run_op(1'b1, 16'd1000, 16'd7, 16'h0006, 16'h008E, 1'b0, 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      chk("no_queued_start", {31'd0, busy}, 32'd0);
      chk("no_queued_hi", {16'd0, hi}, {16'd0, m_hi});

      // Divide 0x1234/0 to leave div_by_zero set before the reset test.
      run_op(1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1'b0, 1'b0);

      // Reset 5 cycles into a divide: immediate clear, no done pulse.
      @(negedge clk);
      start = 1'b1; op = 1'b1; a = 16'd1000; b = 16'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_hi", {16'd0, hi}, 32'd0);
      chk("abort_lo", {16'd0, lo}, 32'd0);
      chk("abort_dbz", {31'd0, dbz}, 32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("abort_no_done", {31'd0, done}, 32'd0);
      end
      reset = 1'b0;
      m_hi = '0; m_lo = '0; m_dbz = 1'b0;
      exp_q.delete();
      repeat (20) begin
         @(negedge clk);
         if (done === 1'b1) chk("abort_late_done", 32'd1, 32'd0);
      end
      chk("abort_idle", {31'd0, busy}, 32'd0);
      run_op(1'b0, 16'd6, 16'd7, 16'h0000, 16'd42, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
